sysbus_arbiter: RTL and testbench

Two-port arbiter and memory-cycle sequencer that shares the single 64-bit external memory bus between two bus masters, such as two core control units or a core and a DMA engine. It grants the bus round-robin and runs the four-phase memory cycle on behalf of the granted master: address setup, address hold, data setup, data hold. It drives nME/nALE/RnW/nOE and the multiplexed address/data lines, and returns read data with a one-cycle acknowledge.

---
 rtl/sysbus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sysbus_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sysbus_arbiter.sv
// Two-master round-robin arbiter that sequences the four-phase multiplexed
// memory cycle (address setup/hold, data setup/hold) for the granted master.
module sysbus_arbiter (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        RnW0,
  input  logic        RnW1,
  input  logic [63:0] Addr0,
  input  logic [63:0] Addr1,
  input  logic [63:0] WData0,
  input  logic [63:0] WData1,
  output logic        Ack0,
  output logic        Ack1,
  output logic [63:0] RData,
  output logic [1:0]  Grant,
  output logic [63:0] BusOut,
  output logic        BusOE,
  input  logic [63:0] BusIn,
  output logic        nME,
  output logic        nALE,
  output logic        RnW,
  output logic        nOE
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ASETUP = 3'd1,
    AHOLD  = 3'd2,
    DSETUP = 3'd3,
    DHOLD  = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic        owner_reg, owner_next;
  logic        last_grant_reg, last_grant_next;
  logic        rnw_reg, rnw_next;
  logic [63:0] addr_reg, addr_next;
  logic [63:0] wdata_reg, wdata_next;
  logic [63:0] rdata_reg, rdata_next;

  logic [1:0]  req_vec;
  logic [1:0]  eligible;
  logic [1:0]  ack_vec;
  logic [1:0]  grant_vec;
  logic        arb_point;
  logic        any_eligible;
  logic        winner;

  assign req_vec   = {Req1, Req0};
  assign arb_point = (state_reg == IDLE) || (state_reg == DHOLD);

  // The owner's own request is masked in DHOLD so a master still holding Req
  // through its Ack cannot be serviced twice.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign eligible[gi]  = req_vec[gi] &&
                             !((state_reg == DHOLD) && (owner_reg == 1'(gi)));
      assign ack_vec[gi]   = (state_reg == DHOLD) && (owner_reg == 1'(gi));
      assign grant_vec[gi] = (state_reg != IDLE) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign any_eligible = |eligible;

  always_comb begin
    winner = 1'b0;
    case (eligible)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant_reg;
      default: winner = 1'b0;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    rnw_next        = rnw_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    rdata_next      = rdata_reg;
    case (state_reg)
      ASETUP: state_next = AHOLD;
      AHOLD:  state_next = DSETUP;
      DSETUP: begin
        state_next = DHOLD;
        if (rnw_reg)
          rdata_next = BusIn;
      end
      IDLE, DHOLD: begin
        if (arb_point && any_eligible) begin
          state_next      = ASETUP;
          owner_next      = winner;
          last_grant_next = winner;
          rnw_next        = winner ? RnW1   : RnW0;
          addr_next       = winner ? Addr1  : Addr0;
          wdata_next      = winner ? WData1 : WData0;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      rnw_reg        <= 1'b1;
      addr_reg       <= 64'h0;
      wdata_reg      <= 64'h0;
      rdata_reg      <= 64'h0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      rnw_reg        <= rnw_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      rdata_reg      <= rdata_next;
    end
  end

  // Strobes are decoded purely from registered state; Req never reaches them.
  always_comb begin
    nME    = 1'b1;
    nALE   = 1'b1;
    RnW    = 1'b1;
    nOE    = 1'b1;
    BusOE  = 1'b0;
    BusOut = 64'h0;
    case (state_reg)
      ASETUP: begin
        BusOE  = 1'b1;
        BusOut = addr_reg;
      end
      AHOLD: begin
        nME    = 1'b0;
        nALE   = 1'b0;
        BusOE  = 1'b1;
        BusOut = addr_reg;
      end
      DSETUP, DHOLD: begin
        nME  = (state_reg == DHOLD);
        nALE = 1'b0;
        if (rnw_reg) begin
          nOE = 1'b0;
        end else begin
          RnW    = 1'b0;
          BusOE  = 1'b1;
          BusOut = wdata_reg;
        end
      end
      default: begin
        nME = 1'b1;
      end
    endcase
  end

  assign Ack0  = ack_vec[0];
  assign Ack1  = ack_vec[1];
  assign Grant = grant_vec;
  assign RData = rdata_reg;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: stimulus pushes expected bus cycles,
// a negedge monitor checks each completed cycle when an Ack appears.
module tb_sysbus_arbiter;

  logic        Clock;
  logic        nReset;
  logic        Req0, Req1, RnW0, RnW1;
  logic [63:0] Addr0, Addr1, WData0, WData1;
  logic        Ack0, Ack1;
  logic [63:0] RData;
  logic [1:0]  Grant;
  logic [63:0] BusOut;
  logic        BusOE;
  logic [63:0] BusIn;
  logic        nME, nALE, RnW, nOE;

  sysbus_arbiter dut (
    .Clock(Clock), .nReset(nReset),
    .Req0(Req0), .Req1(Req1), .RnW0(RnW0), .RnW1(RnW1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Ack0(Ack0), .Ack1(Ack1), .RData(RData), .Grant(Grant),
    .BusOut(BusOut), .BusOE(BusOE), .BusIn(BusIn),
    .nME(nME), .nALE(nALE), .RnW(RnW), .nOE(nOE)
  );

  typedef struct packed {
    logic        port;
    logic        rnw;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [31:0] ack_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          c;
  logic [70:0] hist [4];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic push_exp(input logic port, input logic rnw, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rdata, input int ack_cyc);
    exp_t e;
    e.port = port; e.rnw = rnw; e.addr = addr; e.wdata = wdata;
    e.rdata = rdata; e.ack_cyc = 32'(ack_cyc);
    exp_q.push_back(e);
  endtask

  // Monitor: keep the last four cycles of bus state; on Ack compare the
  // whole four-phase cycle against the next expected transaction.
  always @(negedge Clock) begin
    exp_t       e;
    logic [1:0] g;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {nME, nALE, RnW, nOE, BusOE, Grant, BusOut};
    if (Ack0 || Ack1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 128'({Ack1, Ack0}), 128'(2'b00));
      end else begin
        e = exp_q.pop_front();
        g = e.port ? 2'b10 : 2'b01;
        chk("ack_port", 128'({Ack1, Ack0}), 128'(g));
        chk("ack_cycle", 128'(cyc), 128'(e.ack_cyc));
        chk("rdata", 128'(RData), 128'(e.rdata));
        chk("asetup", 128'(hist[3]), 128'({5'b11111, g, e.addr}));
        chk("ahold", 128'(hist[2]), 128'({5'b00111, g, e.addr}));
        if (e.rnw) begin
          chk("dsetup_rd", 128'(hist[1]), 128'({5'b00100, g, 64'h0}));
          chk("dhold_rd", 128'(hist[0]), 128'({5'b10100, g, 64'h0}));
        end else begin
          chk("dsetup_wr", 128'(hist[1]), 128'({5'b00011, g, e.wdata}));
          chk("dhold_wr", 128'(hist[0]), 128'({5'b10011, g, e.wdata}));
        end
        $display("txn port=%0d rnw=%0d addr=%h rdata=%h cyc=%0d", e.port, e.rnw, e.addr, RData, cyc);
      end
    end
  end

  initial begin
    nReset = 1'b0;
    Req0 = 1'b1; RnW0 = 1'b1; Addr0 = 64'h40; WData0 = 64'h0;
    Req1 = 1'b0; RnW1 = 1'b1; Addr1 = 64'h0;  WData1 = 64'h0;
    BusIn = 64'h0;

    // Reset held 3 edges with Req0 pending: outputs stay idle.
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("rst_strobes", 128'({nME, nALE, RnW, nOE, BusOE}), 128'(5'b11110));
      chk("rst_grant", 128'(Grant), 128'(2'b00));
    end

    // Port 0 read at 0x40; data present on BusIn only during DSETUP.
    c = cyc;
    nReset = 1'b1;
    push_exp(1'b0, 1'b1, 64'h40, 64'h0, 64'hDEAD_BEEF_0123_4567, c + 4);
    tick(3);
    BusIn = 64'hDEAD_BEEF_0123_4567;
    tick(1);
    BusIn = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(1);
    Req0 = 1'b0;

    // Port 1 write at 0x80; RData must keep the previous read value.
    c = cyc;
    Req1 = 1'b1; RnW1 = 1'b0; Addr1 = 64'h80; WData1 = 64'h1122_3344_5566_7788;
    push_exp(1'b1, 1'b0, 64'h80, 64'h1122_3344_5566_7788, 64'hDEAD_BEEF_0123_4567, c + 4);
    tick(5);
    Req1 = 1'b0;

    // Contention: both held, port 0 first (last grant was port 1), no gaps.
    c = cyc;
    BusIn = 64'hA5A5_5A5A_0F0F_F0F0;
    Req0 = 1'b1; RnW0 = 1'b1; Addr0 = 64'h100;
    Req1 = 1'b1; RnW1 = 1'b0; Addr1 = 64'h180; WData1 = 64'hCAFE_F00D_0000_0001;
    push_exp(1'b0, 1'b1, 64'h100, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, c + 4);
    push_exp(1'b1, 1'b0, 64'h180, 64'hCAFE_F00D_0000_0001, 64'hA5A5_5A5A_0F0F_F0F0, c + 8);
    push_exp(1'b0, 1'b1, 64'h100, 64'h0, 64'hA5A5_5A5A_0F0F_F0F0, c + 12);
    push_exp(1'b1, 1'b0, 64'h180, 64'hCAFE_F00D_0000_0001, 64'hA5A5_5A5A_0F0F_F0F0, c + 16);
    tick(13);
    Req0 = 1'b0;
    tick(4);
    Req1 = 1'b0;
    chk("contention_idle_grant", 128'(Grant), 128'(2'b00));
    chk("contention_idle_nme", 128'(nME), 128'(1'b1));

    // Reset during DSETUP of a read abandons it; pending Req is re-serviced.
    c = cyc;
    BusIn = 64'h0123_4567_89AB_CDEF;
    Req0 = 1'b1; RnW0 = 1'b1; Addr0 = 64'h200;
    tick(3);
    chk("pre_reset_grant", 128'(Grant), 128'(2'b01));
    chk("pre_reset_noe", 128'(nOE), 128'(1'b0));
    nReset = 1'b0;
    tick(1);
    chk("midrst_ack", 128'({Ack1, Ack0}), 128'(2'b00));
    chk("midrst_busoe", 128'(BusOE), 128'(1'b0));
    chk("midrst_grant", 128'(Grant), 128'(2'b00));
    chk("midrst_strobes", 128'({nME, nALE, RnW, nOE}), 128'(4'b1111));
    chk("midrst_rdata", 128'(RData), 128'(64'h0));
    nReset = 1'b1;
    push_exp(1'b0, 1'b1, 64'h200, 64'h0, 64'h0123_4567_89AB_CDEF, c + 8);
    tick(5);
    Req0 = 1'b0;

    // Req0 write dropped in AHOLD: cycle still completes with one Ack.
    c = cyc;
    Req0 = 1'b1; RnW0 = 1'b0; Addr0 = 64'h300; WData0 = 64'h5555_AAAA_5555_AAAA;
    push_exp(1'b0, 1'b0, 64'h300, 64'h5555_AAAA_5555_AAAA, 64'h0123_4567_89AB_CDEF, c + 4);
    tick(2);
    Req0 = 1'b0;
    tick(3);
    chk("drop_idle_grant", 128'(Grant), 128'(2'b00));
    chk("drop_idle_strobes", 128'({nME, nALE, BusOE}), 128'(3'b110));
    tick(4);
    chk("pending_expected", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
